// File: rtl/prescaled_counter_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prescaled_counter_bank_pkg
//  Description : Shared constants and types for the prescaled counter bank.
//                Holds the reset-time divide values (channel 0 counts every
//                enabled cycle, the other channels every fourth) and the
//                channel-index type used to look them up.
//  Revision    : 1.0  initial release
// ============================================================================
package prescaled_counter_bank_pkg;

    localparam int c_DIV_DEFAULT_CH0   = 1;
    localparam int c_DIV_DEFAULT_OTHER = 4;

    typedef logic [7:0] chan_idx_t;

    // Reset divide value for a given channel, before truncation to PRESC_W.
    function automatic int default_div(input chan_idx_t ch);
        return (ch == '0) ? c_DIV_DEFAULT_CH0 : c_DIV_DEFAULT_OTHER;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prescaled_counter_channel.sv
`default_nettype none
// ============================================================================
//  Module      : prescaled_counter_channel
//  Description : One counter channel: divide register, prescaler, event
//                counter and wrap flag. The counter advances once every
//                E enabled cycles, where E is the divide register value
//                (a value of 0 behaves as 1).
//  Revision    : 1.0  initial release
//  Config      : COUNTER_SAT_EN - counter saturates at all-ones and the wrap
//                flag becomes a level; otherwise the counter wraps and the
//                flag is a one-cycle pulse.
//  Ports       : i_clk      clock, rising edge
//                i_rst      asynchronous active-high reset
//                i_sel      this channel is addressed
//                i_en       count enable
//                i_clr      clear prescaler, counter and wrap flag
//                i_div_we   load divide register from i_div_in
//                i_div_in   new divide value
//                o_count    counter value (register)
//                o_wrap     rollover pulse / saturation level
// ============================================================================
module prescaled_counter_channel
    import prescaled_counter_bank_pkg::*;
#(
    parameter int                   WIDTH     = 64,
    parameter int                   PRESC_W   = 3,
    parameter logic [PRESC_W-1:0]   RESET_DIV = '0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_sel,
    input  logic               i_en,
    input  logic               i_clr,
    input  logic               i_div_we,
    input  logic [PRESC_W-1:0] i_div_in,
    output logic [WIDTH-1:0]   o_count,
    output logic               o_wrap
);

    logic [PRESC_W-1:0] r_div;
    logic [PRESC_W-1:0] r_presc;
    logic [WIDTH-1:0]   r_count;
    logic               r_wrap;

    logic [PRESC_W-1:0] w_eff;
    logic               w_terminal;
    logic               w_inc;
    logic               w_roll;
    logic               w_cnt_max;
    logic [WIDTH-1:0]   w_cnt_next;
    logic               w_wrap_next;

    assign w_eff      = (r_div == '0) ? PRESC_W'(1) : r_div;
    assign w_terminal = (r_presc == (w_eff - PRESC_W'(1)));
    // Clear wins over a simultaneous increment.
    assign w_inc      = i_sel & i_en & ~i_clr;
    assign w_roll     = w_inc & w_terminal;
    assign w_cnt_max  = (r_count == '1);

`ifdef COUNTER_SAT_EN
    assign w_cnt_next  = (w_roll && !w_cnt_max) ? r_count + WIDTH'(1) : r_count;
    // Level: stays high for as long as the counter sits at all-ones.
    assign w_wrap_next = (w_cnt_next == '1);
`else
    assign w_cnt_next  = w_roll ? r_count + WIDTH'(1) : r_count;
    assign w_wrap_next = w_roll & w_cnt_max;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div   <= RESET_DIV;
            r_presc <= '0;
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (i_sel && i_clr) begin
            r_presc <= '0;
            r_count <= '0;
            r_wrap  <= 1'b0;
            if (i_div_we) begin
                r_div <= i_div_in;
            end
        end else begin
            r_count <= w_cnt_next;
            r_wrap  <= w_wrap_next;
            // A divide write restarts the prescaler; the counter update of
            // this edge already used the old divide value above.
            if (i_sel && i_div_we) begin
                r_div   <= i_div_in;
                r_presc <= '0;
            end else if (w_inc) begin
                r_presc <= w_terminal ? '0 : r_presc + PRESC_W'(1);
            end
        end
    end

    assign o_count = r_count;
    assign o_wrap  = r_wrap;

endmodule
`default_nettype wire

// File: rtl/prescaled_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : prescaled_counter_bank
//  Description : Bank of CHANNELS independent prescaled event counters.
//                Slt addresses one channel for En / Clr / Div_We; a select
//                value >= CHANNELS addresses nothing.
//  Revision    : 1.0  initial release
//  Config      : COUNTER_SAT_EN - saturating counters with level wrap flag.
//  Ports       : Clk     clock, rising edge
//                Reset   asynchronous active-high reset
//                En      count enable for the selected channel
//                Slt     channel select
//                Clr     synchronous clear of the selected channel
//                Div_We  divide register write strobe
//                Div_In  divide value
//                Count   flattened counters, channel k at [k*WIDTH +: WIDTH]
//                Wrap    per-channel rollover/saturation flag
// ============================================================================
module prescaled_counter_bank
    import prescaled_counter_bank_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int CHANNELS = 4,
    parameter int PRESC_W  = 3,
    parameter int SEL_W    = 2
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      En,
    input  logic [SEL_W-1:0]          Slt,
    input  logic                      Clr,
    input  logic                      Div_We,
    input  logic [PRESC_W-1:0]        Div_In,
    output logic [CHANNELS*WIDTH-1:0] Count,
    output logic [CHANNELS-1:0]       Wrap
);

    logic [CHANNELS-1:0] w_sel;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        localparam int                 c_DEF_INT = default_div(chan_idx_t'(k));
        localparam logic [PRESC_W-1:0] c_DEF_DIV = c_DEF_INT[PRESC_W-1:0];

        logic [WIDTH-1:0] w_count;

        // Out-of-range select values never match any channel.
        assign w_sel[k] = (Slt == SEL_W'(k));

        prescaled_counter_channel #(
            .WIDTH     (WIDTH),
            .PRESC_W   (PRESC_W),
            .RESET_DIV (c_DEF_DIV)
        ) u_chan (
            .i_clk    (Clk),
            .i_rst    (Reset),
            .i_sel    (w_sel[k]),
            .i_en     (En),
            .i_clr    (Clr),
            .i_div_we (Div_We),
            .i_div_in (Div_In),
            .o_count  (w_count),
            .o_wrap   (Wrap[k])
        );

        assign Count[k*WIDTH +: WIDTH] = w_count;
    end

endmodule
`default_nettype wire

// File: tb/tb_prescaled_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prescaled_counter_bank
//  Description : Directed self-checking bench for prescaled_counter_bank,
//                built with WIDTH=4, CHANNELS=4, PRESC_W=3, SEL_W=3 so that
//                rollover and out-of-range selects are reachable.
//                Count nibbles read {ch3,ch2,ch1,ch0}.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prescaled_counter_bank;

    localparam int WIDTH    = 4;
    localparam int CHANNELS = 4;
    localparam int PRESC_W  = 3;
    localparam int SEL_W    = 3;

    logic                      Clk;
    logic                      Reset;
    logic                      En;
    logic [SEL_W-1:0]          Slt;
    logic                      Clr;
    logic                      Div_We;
    logic [PRESC_W-1:0]        Div_In;
    logic [CHANNELS*WIDTH-1:0] Count;
    logic [CHANNELS-1:0]       Wrap;

    int n_checks = 0;
    int n_fail   = 0;

    prescaled_counter_bank #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .PRESC_W  (PRESC_W),
        .SEL_W    (SEL_W)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .En     (En),
        .Slt    (Slt),
        .Clr    (Clr),
        .Div_We (Div_We),
        .Div_In (Div_In),
        .Count  (Count),
        .Wrap   (Wrap)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int slt, input logic en, input logic clr,
                         input logic we, input int din);
        Slt    = SEL_W'(slt);
        En     = en;
        Clr    = clr;
        Div_We = we;
        Div_In = PRESC_W'(din);
    endtask

    // Apply current inputs for n edges; returns at a falling edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            @(negedge Clk);
        end
    endtask

    // Reset pulsed between clock edges, released before the next rising edge.
    task automatic async_reset(input string tag);
        #2 Reset = 1'b1;
        #1;
        check({tag, "_count"}, 64'(Count), 64'h0);
        check({tag, "_wrap"},  64'(Wrap),  64'h0);
        #1 Reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 0);
        #2;
        check("reset_count", 64'(Count), 64'h0);
        check("reset_wrap",  64'(Wrap),  64'h0);
        @(negedge Clk);
        Reset = 1'b0;

        // Channel 0 divides by 1: five enabled cycles give 5.
        drive(0, 1'b1, 1'b0, 1'b0, 0);
        run(5);
        check("ch0_five", 64'(Count), 64'h0005);
        check("ch0_five_wrap", 64'(Wrap), 64'h0);

        // Channel 1 divides by 4: 9 cycles -> 2 (prescaler at 1).
        drive(0, 1'b0, 1'b0, 1'b0, 0);
        async_reset("rst2");
        drive(1, 1'b1, 1'b0, 1'b0, 0);
        run(9);
        check("ch1_nine", 64'(Count), 64'h0020);
        run(2);
        check("ch1_eleven", 64'(Count), 64'h0020);
        run(1);
        check("ch1_twelve", 64'(Count), 64'h0030);

        // Divide 0 behaves as 1 on channel 2.
        drive(2, 1'b0, 1'b0, 1'b1, 0);
        run(1);
        check("ch2_divwr", 64'(Count), 64'h0030);
        drive(2, 1'b1, 1'b0, 1'b0, 0);
        run(3);
        check("ch2_div0", 64'(Count), 64'h0330);

        // Out-of-range select touches nothing.
        drive(5, 1'b1, 1'b1, 1'b1, 0);
        run(2);
        check("sel_oor", 64'(Count), 64'h0330);
        check("sel_oor_wrap", 64'(Wrap), 64'h0);

        // Bring ch1 to 7 with divide 1, then Clr+En together.
        drive(1, 1'b0, 1'b0, 1'b1, 1);
        run(1);
        drive(1, 1'b1, 1'b0, 1'b0, 0);
        run(4);
        check("ch1_seven", 64'(Count), 64'h0370);
        drive(1, 1'b1, 1'b1, 1'b0, 0);
        run(1);
        check("ch1_clr", 64'(Count), 64'h0300);
        check("ch1_clr_wrap", 64'(Wrap), 64'h0);

        // Divide write with simultaneous increment uses old divide (1).
        drive(2, 1'b1, 1'b0, 1'b1, 2);
        run(1);
        check("ch2_we_inc", 64'(Count), 64'h0400);
        drive(2, 1'b1, 1'b0, 1'b0, 0);
        run(1);
        check("ch2_newdiv_a", 64'(Count), 64'h0400);
        run(1);
        check("ch2_newdiv_b", 64'(Count), 64'h0500);

        // Channel 0 up to all-ones, then one more increment.
        drive(0, 1'b1, 1'b0, 1'b0, 0);
        run(15);
        check("ch0_max", 64'(Count), 64'h050F);
`ifdef COUNTER_SAT_EN
        check("ch0_max_wrap", 64'(Wrap), 64'h1);
`else
        check("ch0_max_wrap", 64'(Wrap), 64'h0);
`endif
        run(1);
`ifdef COUNTER_SAT_EN
        check("ch0_over", 64'(Count), 64'h050F);
`else
        check("ch0_over", 64'(Count), 64'h0500);
`endif
        check("ch0_over_wrap", 64'(Wrap), 64'h1);
        drive(0, 1'b0, 1'b0, 1'b0, 0);
        run(1);
`ifdef COUNTER_SAT_EN
        check("ch0_wrap_after", 64'(Wrap), 64'h1);
`else
        check("ch0_wrap_after", 64'(Wrap), 64'h0);
`endif
        drive(0, 1'b0, 1'b1, 1'b0, 0);
        run(1);
        check("ch0_clr", 64'(Count), 64'h0500);
        check("ch0_clr_wrap", 64'(Wrap), 64'h0);

        // Channel 3 mid-count, then asynchronous reset.
        drive(3, 1'b1, 1'b0, 1'b0, 0);
        run(6);
        check("ch3_six", 64'(Count), 64'h1500);
        async_reset("rst3");
        run(3);
        check("ch3_post_rst3", 64'(Count), 64'h0000);
        run(1);
        check("ch3_post_rst4", 64'(Count), 64'h1000);
        drive(0, 1'b1, 1'b0, 1'b0, 0);
        run(1);
        check("ch0_post_rst", 64'(Count), 64'h1001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prescaled_counter_bank.md
PRESCALED_COUNTER_BANK -- requirements
Module: prescaled_counter_bank

Interface
REQ-001 Parameter WIDTH, default 64, bit width of each event counter.
REQ-002 Parameter CHANNELS, default 4, number of independent counter channels (>= 2).
REQ-003 Parameter PRESC_W, default 3, bit width of each channel's prescaler and divide register.
REQ-004 Parameter SEL_W, default 2, channel-select width; the instantiating design SHALL supply a value >= clog2(CHANNELS).
REQ-005 Port Clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port Reset  input  1  asynchronous, active-high reset.
REQ-007 Port En  input  1  count enable; qualifies every increment.
REQ-008 Port Slt  input  SEL_W  selects the channel that En, Clr and Div_We act on.
REQ-009 Port Clr  input  1  synchronous clear of the selected channel.
REQ-010 Port Div_We  input  1  write strobe for the selected channel's divide register.
REQ-011 Port Div_In  input  PRESC_W  divide value written on Div_We.
REQ-012 Port Count  output  CHANNELS*WIDTH  flattened counters, channel k at bits [k*WIDTH +: WIDTH].
REQ-013 Port Wrap  output  CHANNELS  per-channel rollover/saturation flag.

Function
REQ-014 Each channel SHALL hold a divide register D[k], a prescaler P[k] and a counter C[k].
REQ-015 Effective divide SHALL be E[k] = D[k], except that D[k] = 0 SHALL be treated as E[k] = 1.
REQ-016 On a cycle with En = 1, Clr = 0 and Slt = k, P[k] SHALL increment; when P[k] = E[k]-1, P[k] SHALL go to 0 and C[k] SHALL increment in the same edge.
REQ-017 Unselected channels, and all channels when En = 0, SHALL hold P and C unchanged.
REQ-018 An Slt value >= CHANNELS SHALL select no channel; En, Clr and Div_We SHALL then have no effect.
REQ-019 Clr = 1 SHALL zero P[k] and C[k] of the selected channel and clear Wrap[k]; Clr SHALL take priority over a simultaneous increment.
REQ-020 Div_We = 1 SHALL load D[k] from Div_In and zero P[k]; a simultaneous increment SHALL update C[k] using the old E[k], and the new E[k] SHALL apply from the next cycle.
REQ-021 Count SHALL be a registered output, with zero-cycle latency from the counter registers.
REQ-022 Counter arithmetic SHALL be unsigned modulo 2^WIDTH unless REQ-027 applies.
REQ-023 Without saturation, Wrap[k] SHALL be a one-cycle pulse on the edge where C[k] rolls from all-ones to 0.

Reset
REQ-024 Asserting Reset SHALL immediately set all C, P and Wrap to 0, independent of Clk.
REQ-025 Asserting Reset SHALL immediately set D[0] = 1 and D[k] = 4 for k >= 1, truncated to PRESC_W bits.
REQ-026 Reset asserted mid-count SHALL discard partial prescaler progress; counting SHALL resume on the first edge after deassertion.

Configuration
REQ-027 When macro COUNTER_SAT_EN is defined, C[k] SHALL stop at all-ones instead of wrapping, and Wrap[k] SHALL be a level held high while C[k] is all-ones until Clr or Reset.
REQ-028 When COUNTER_SAT_EN is undefined, the wrap behaviour of REQ-022/REQ-023 SHALL apply, with no saturation logic present.

Structure
REQ-029 A shared package SHALL hold the default divide constants (1 for channel 0, 4 for other channels) and the channel-index type.
REQ-030 One sub-module, prescaled_counter_channel, SHALL implement D, P, C and Wrap for a single channel; the top SHALL instantiate CHANNELS copies and decode Slt.

Verification
REQ-031 Reset, then En = 1 with Slt = 0 for 5 cycles -> Count[ch0] = 5 and all other channels = 0.
REQ-032 Reset, then En = 1 with Slt = 1 for 9 cycles -> Count[ch1] = 2 and P[1] = 1; after 3 more cycles -> Count[ch1] = 3.
REQ-033 Div_We with Div_In = 0 on ch2, then 3 enabled cycles -> Count[ch2] = 3 (divide treated as 1).
REQ-034 With WIDTH = 4, preload ch0 to 15, then one increment -> Count = 0 with a one-cycle Wrap[0] pulse; under COUNTER_SAT_EN -> Count = 15 and Wrap[0] held high.
REQ-035 Clr and En together on ch1 with Count = 7 -> Count[ch1] = 0 and Wrap[1] = 0.
REQ-036 Reset pulsed between clock edges while ch3 counts -> all outputs 0 immediately, and D[3] = 4.
